// File: rtl/text_line_arbiter.sv
// text_line_arbiter
// One shared 10-character text line serves NUM_REQ requesters. The line goes
// to one owner at a time. The owner's string and position are latched, the
// string is revealed one character every REVEAL_FRAMES frame ticks, held for
// HOLD_FRAMES frame ticks, and then the line is released.
// Optional feature macro: TEXT_ARB_RR_EN selects round-robin arbitration.
// When it is undefined, the lowest requester index wins.
module text_line_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int REVEAL_FRAMES = 4,
  parameter int HOLD_FRAMES   = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*80-1:0] str_in,
  input  logic [NUM_REQ*4-1:0]  len_in,
  input  logic [NUM_REQ*20-1:0] pos_in,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy,
  output logic                  done,
  output logic [9:0]            start_x,
  output logic [9:0]            start_y,
  output logic [7:0]            char0,
  output logic [7:0]            char1,
  output logic [7:0]            char2,
  output logic [7:0]            char3,
  output logic [7:0]            char4,
  output logic [7:0]            char5,
  output logic [7:0]            char6,
  output logic [7:0]            char7,
  output logic [7:0]            char8,
  output logic [7:0]            char9,
  output logic [3:0]            str_length
);

  localparam int OW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_FRAMES = (REVEAL_FRAMES > HOLD_FRAMES) ? REVEAL_FRAMES : HOLD_FRAMES;
  localparam int CW         = $clog2(MAX_FRAMES + 1);

  localparam logic [CW-1:0] REVEAL_LAST = CW'(REVEAL_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_FRAMES - 1);
  localparam logic [79:0]   BLANK_LINE  = {10{8'd32}};
  localparam logic [3:0]    MAX_LEN     = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_REVEAL = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t              state_r;
  logic [OW-1:0]       owner_r;
  logic [NUM_REQ-1:0]  grant_r;
  logic                busy_r;
  logic                done_r;
  logic [9:0]          start_x_r;
  logic [9:0]          start_y_r;
  logic [79:0]         chars_r;
  logic [3:0]          str_length_r;
  logic [3:0]          len_r;
  logic [CW-1:0]       frame_cnt_r;

  logic [OW-1:0]       win_idx_s;
  logic [NUM_REQ-1:0]  win_grant_s;
  logic                any_req_s;
  logic                abandon_s;
  logic [79:0]         sel_str_s;
  logic [3:0]          sel_len_s;
  logic [19:0]         sel_pos_s;
  logic [3:0]          len_clamp_s;
  logic [79:0]         masked_chars_s;

`ifdef TEXT_ARB_RR_EN
  logic [OW-1:0]       last_owner_r;

  // The search starts just after the last owner. Candidates are visited
  // backwards, so the first one in search order is the value that remains.
  function automatic logic [OW-1:0] pick_rr(input logic [NUM_REQ-1:0] r,
                                            input logic [OW-1:0]      last);
    logic [OW-1:0] idx;
    int            cand;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(last) + 1 + i) % NUM_REQ;
      if (r[cand]) begin
        idx = OW'(cand);
      end
    end
    return idx;
  endfunction

  assign win_idx_s = pick_rr(req, last_owner_r);
`else
  // Fixed priority. The scan runs from high index to low, so the lowest set
  // index is the value that remains.
  function automatic logic [OW-1:0] pick_fixed(input logic [NUM_REQ-1:0] r);
    logic [OW-1:0] idx;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[i]) begin
        idx = OW'(i);
      end
    end
    return idx;
  endfunction

  assign win_idx_s = pick_fixed(req);
`endif

  assign win_grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
  assign any_req_s   = |req;

  // Only the owner's own request line can abandon the grant.
  assign abandon_s = ((state_r == ST_LOAD) || (state_r == ST_REVEAL) || (state_r == ST_HOLD))
                     && !req[owner_r];

  assign sel_str_s   = str_in[80*int'(owner_r) +: 80];
  assign sel_len_s   = len_in[4*int'(owner_r) +: 4];
  assign sel_pos_s   = pos_in[20*int'(owner_r) +: 20];
  assign len_clamp_s = (sel_len_s > MAX_LEN) ? MAX_LEN : sel_len_s;

  // Blank every character position at or beyond the clamped length.
  always_comb begin
    masked_chars_s = BLANK_LINE;
    for (int k = 0; k < 10; k++) begin
      if (k < int'(len_clamp_s)) begin
        masked_chars_s[8*k +: 8] = sel_str_s[8*k +: 8];
      end else begin
        masked_chars_s[8*k +: 8] = 8'd32;
      end
    end
  end

  // Arbitration, latching, and the reveal/hold sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= '0;
      grant_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      start_x_r    <= 10'd0;
      start_y_r    <= 10'd0;
      chars_r      <= BLANK_LINE;
      str_length_r <= 4'd0;
      len_r        <= 4'd0;
      frame_cnt_r  <= '0;
`ifdef TEXT_ARB_RR_EN
      last_owner_r <= OW'(NUM_REQ - 1);
`endif
    end else if (abandon_s) begin
      // The owner withdrew. Release the line at once and skip the done pulse.
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      chars_r      <= BLANK_LINE;
      str_length_r <= 4'd0;
      frame_cnt_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            owner_r <= win_idx_s;
            grant_r <= win_grant_s;
            busy_r  <= 1'b1;
            state_r <= ST_LOAD;
`ifdef TEXT_ARB_RR_EN
            last_owner_r <= win_idx_s;
`endif
          end
        end
        ST_LOAD: begin
          chars_r      <= masked_chars_s;
          start_x_r    <= sel_pos_s[9:0];
          start_y_r    <= sel_pos_s[19:10];
          len_r        <= len_clamp_s;
          str_length_r <= 4'd0;
          frame_cnt_r  <= '0;
          if (len_clamp_s == 4'd0) begin
            state_r <= ST_HOLD;
          end else begin
            state_r <= ST_REVEAL;
          end
        end
        ST_REVEAL: begin
          if (frame_tick) begin
            if (frame_cnt_r == REVEAL_LAST) begin
              frame_cnt_r  <= '0;
              str_length_r <= str_length_r + 4'd1;
              if ((str_length_r + 4'd1) == len_r) begin
                state_r <= ST_HOLD;
              end else begin
                state_r <= ST_REVEAL;
              end
            end else begin
              frame_cnt_r <= frame_cnt_r + CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (frame_tick) begin
            if (frame_cnt_r == HOLD_LAST) begin
              frame_cnt_r  <= '0;
              state_r      <= ST_DONE;
              done_r       <= 1'b1;
              grant_r      <= '0;
              str_length_r <= 4'd0;
              chars_r      <= BLANK_LINE;
            end else begin
              frame_cnt_r <= frame_cnt_r + CW'(1);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          grant_r      <= '0;
          busy_r       <= 1'b0;
          chars_r      <= BLANK_LINE;
          str_length_r <= 4'd0;
          frame_cnt_r  <= '0;
        end
      endcase
    end
  end

  assign grant      = grant_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign start_x    = start_x_r;
  assign start_y    = start_y_r;
  assign str_length = str_length_r;
  assign char0      = chars_r[7:0];
  assign char1      = chars_r[15:8];
  assign char2      = chars_r[23:16];
  assign char3      = chars_r[31:24];
  assign char4      = chars_r[39:32];
  assign char5      = chars_r[47:40];
  assign char6      = chars_r[55:48];
  assign char7      = chars_r[63:56];
  assign char8      = chars_r[71:64];
  assign char9      = chars_r[79:72];

endmodule

// File: tb/tb_text_line_arbiter.sv
// Directed, table-driven bench for text_line_arbiter.
// It uses REVEAL_FRAMES=2 and HOLD_FRAMES=3.
module tb_text_line_arbiter;

  localparam int RF = 2;
  localparam int HF = 3;
  localparam logic [79:0] BLANK = {10{8'd32}};

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [3:0]  req;
  logic [319:0] str_in;
  logic [15:0] len_in;
  logic [79:0] pos_in;
  logic [3:0]  grant;
  logic        busy;
  logic        done;
  logic [9:0]  start_x;
  logic [9:0]  start_y;
  logic [7:0]  char0, char1, char2, char3, char4, char5, char6, char7, char8, char9;
  logic [3:0]  str_length;
  logic [79:0] line_s;

  int checks = 0;
  int errors = 0;

  text_line_arbiter #(.NUM_REQ(4), .REVEAL_FRAMES(RF), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .req(req),
    .str_in(str_in), .len_in(len_in), .pos_in(pos_in),
    .grant(grant), .busy(busy), .done(done),
    .start_x(start_x), .start_y(start_y),
    .char0(char0), .char1(char1), .char2(char2), .char3(char3), .char4(char4),
    .char5(char5), .char6(char6), .char7(char7), .char8(char8), .char9(char9),
    .str_length(str_length)
  );

  always #5 clk = ~clk;

  assign line_s = {char9, char8, char7, char6, char5, char4, char3, char2, char1, char0};

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  len;
    logic [79:0] str;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  exp_grant;
    logic [3:0]  exp_len;
    logic [79:0] exp_line;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [79:0] mk_str(input string s);
    logic [79:0] v;
    v = {10{8'd32}};
    for (int k = 0; k < 10; k++) begin
      if (k < s.len()) v[8*k +: 8] = s[k];
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [79:0] s, input logic [3:0] l,
                          input logic [19:0] p);
    str_in[80*i +: 80] = s;
    len_in[4*i +: 4]   = l;
    pos_in[20*i +: 20] = p;
  endtask

  task automatic tick1();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_grant"}, 80'(grant), 80'd0);
    chk({tag, "_busy"}, 80'(busy), 80'd0);
    chk({tag, "_done"}, 80'(done), 80'd0);
    chk({tag, "_str_length"}, 80'(str_length), 80'd0);
    chk({tag, "_chars"}, line_s, BLANK);
    chk({tag, "_start_x"}, 80'(start_x), 80'd0);
    chk({tag, "_start_y"}, 80'(start_y), 80'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int total;
    int exp_sl;
    for (int i = 0; i < 4; i++) begin
      if (v.req[i]) set_slot(i, v.str, v.len, {v.y, v.x});
      else          set_slot(i, mk_str("QQQQQQQQQQ"), 4'd9, 20'hFFFFF);
    end
    req = v.req;
    @(negedge clk);
    chk("vec_grant", 80'(grant), 80'(v.exp_grant));
    chk("vec_busy", 80'(busy), 80'd1);
    @(negedge clk);
    chk("vec_line", line_s, v.exp_line);
    chk("vec_start_x", 80'(start_x), 80'(v.x));
    chk("vec_start_y", 80'(start_y), 80'(v.y));
    chk("vec_len_at_load", 80'(str_length), 80'd0);
    total = int'(v.exp_len) * RF + HF;
    for (int t = 1; t <= total; t++) begin
      tick1();
      if (t < total) begin
        exp_sl = t / RF;
        if (exp_sl > int'(v.exp_len)) exp_sl = int'(v.exp_len);
        chk("vec_str_length", 80'(str_length), 80'(exp_sl));
        chk("vec_done_early", 80'(done), 80'd0);
      end else begin
        chk("vec_done", 80'(done), 80'd1);
        chk("vec_grant_done", 80'(grant), 80'd0);
        chk("vec_line_done", line_s, BLANK);
        chk("vec_len_done", 80'(str_length), 80'd0);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    chk("vec_done_one_cycle", 80'(done), 80'd0);
    chk("vec_busy_end", 80'(busy), 80'd0);
  endtask

  initial begin
    logic [3:0] exp_regrant;
    logic       seen_done;
    rst = 1'b1; frame_tick = 1'b0; req = 4'b0000;
    str_in = '0; len_in = '0; pos_in = '0;

    vecs[0] = '{4'b0010, 4'd5,  mk_str("SCOREXYZAB"), 10'd100, 10'd40,  4'b0010, 4'd5,  mk_str("SCORE")};
    vecs[1] = '{4'b0010, 4'd15, mk_str("0123456789"), 10'd640, 10'd480, 4'b0010, 4'd10, mk_str("0123456789")};
    vecs[2] = '{4'b0001, 4'd0,  mk_str("HELLOWORLD"), 10'd1,   10'd2,   4'b0001, 4'd0,  BLANK};
    vecs[3] = '{4'b1000, 4'd10, mk_str("GAME OVER!"), 10'd300, 10'd200, 4'b1000, 4'd10, mk_str("GAME OVER!")};
    vecs[4] = '{4'b0100, 4'd1,  mk_str("ABCDEFGHIJ"), 10'd1023, 10'd0,  4'b0100, 4'd1,  mk_str("A")};

    repeat (3) @(negedge clk);
    check_reset("init");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 80'(busy), 80'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset in the middle of REVEAL, with the request still held.
    set_slot(2, mk_str("ABCDWXYZAB"), 4'd4, {10'd200, 10'd300});
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_line", line_s, mk_str("ABCD"));
    tick1();
    tick1();
    chk("rstmid_progress", 80'(str_length), 80'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rstmid");
    @(negedge clk);
    chk("rstmid_done2", 80'(done), 80'd0);
    @(negedge clk);
    chk("rstmid_done3", 80'(done), 80'd0);
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    chk("rstmid_idle", 80'(busy), 80'd0);

    // Priority on a simultaneous request, then re-arbitration after DONE.
    set_slot(1, mk_str("AAAAAAAAAA"), 4'd0, 20'd0);
    set_slot(3, mk_str("BBBBBBBBBB"), 4'd0, 20'd0);
    req = 4'b1010;
    @(negedge clk);
    chk("prio_grant", 80'(grant), 80'(4'b0010));
    @(negedge clk);
    chk("prio_zero_len", 80'(str_length), 80'd0);
    tick1(); tick1(); tick1();
    chk("prio_done", 80'(done), 80'd1);
    @(negedge clk);
    chk("prio_gap_grant", 80'(grant), 80'd0);
    chk("prio_gap_done", 80'(done), 80'd0);
    @(negedge clk);
`ifdef TEXT_ARB_RR_EN
    exp_regrant = 4'b1000;
`else
    exp_regrant = 4'b0010;
`endif
    chk("prio_regrant", 80'(grant), 80'(exp_regrant));
    req = 4'b0000;
    @(negedge clk);
    chk("abandon_load_busy", 80'(busy), 80'd0);
    chk("abandon_load_done", 80'(done), 80'd0);

    // Abandon on the same cycle as the tick that would reveal a character.
    set_slot(0, mk_str("XYZ"), 4'd3, {10'd9, 10'd8});
    req = 4'b0001;
    @(negedge clk);
    chk("abd_grant", 80'(grant), 80'(4'b0001));
    @(negedge clk);
    tick1();
    chk("abd_pre", 80'(str_length), 80'd0);
    frame_tick = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("abd_grant_off", 80'(grant), 80'd0);
    chk("abd_busy", 80'(busy), 80'd0);
    chk("abd_str_length", 80'(str_length), 80'd0);
    seen_done = done;
    for (int c = 0; c < 8; c++) begin
      frame_tick = ~frame_tick;
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    frame_tick = 1'b0;
    chk("abd_no_done", 80'(seen_done), 80'd0);

    // Inputs that change during HOLD must not reach the latched line.
    for (int i = 0; i < 3; i++) set_slot(i, mk_str("QQQQQQQQQQ"), 4'd9, 20'hFFFFF);
    set_slot(3, mk_str("HIJKLMNOPQ"), 4'd2, {10'd7, 10'd5});
    req = 4'b1000;
    @(negedge clk);
    chk("iso_grant", 80'(grant), 80'(4'b1000));
    @(negedge clk);
    chk("iso_line", line_s, mk_str("HI"));
    tick1(); tick1(); tick1(); tick1();
    chk("iso_revealed", 80'(str_length), 80'd2);
    tick1();
    for (int i = 0; i < 4; i++) set_slot(i, mk_str("ZZZZZZZZZZ"), 4'hF, 20'hFFFFF);
    @(negedge clk);
    chk("iso_line_hold", line_s, mk_str("HI"));
    chk("iso_x_hold", 80'(start_x), 80'd5);
    chk("iso_y_hold", 80'(start_y), 80'd7);
    chk("iso_len_hold", 80'(str_length), 80'd2);
    tick1();
    chk("iso_line_hold2", line_s, mk_str("HI"));
    chk("iso_no_done", 80'(done), 80'd0);
    tick1();
    chk("iso_done", 80'(done), 80'd1);
    chk("iso_line_done", line_s, BLANK);
    req = 4'b0000;
    @(negedge clk);
    chk("iso_idle", 80'(busy), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_line_arbiter.md
Name: text_line_arbiter

Overview:
- Shares one 10-character text line (the on-screen string renderer fed by char0..char9, str_length, start_x, start_y) between NUM_REQ requesters (score, status, game-over banner, etc.).
- Grants the line to one requester at a time and latches that requester's string and position.
- Reveals the string typewriter-style, one character per REVEAL_FRAMES frame ticks, then holds it for HOLD_FRAMES frame ticks and releases the line.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REVEAL_FRAMES, 4, frame_tick count per revealed character (>=1).
- HOLD_FRAMES, 60, frame_tick count the full string stays visible after reveal (>=1).

Ports:
- clk  in  1  system clock (pixel/system domain, single clock).
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- req  in  NUM_REQ  request lines; held high until done or abandon.
- str_in  in  NUM_REQ*80  packed strings; requester i at [80i+79:80i], char k at bits [8k+7:8k].
- len_in  in  NUM_REQ*4  string lengths.
- pos_in  in  NUM_REQ*20  positions; {y[9:0], x[9:0]} per requester.
- grant  out  NUM_REQ  one-hot owner of the line.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a display completes normally.
- start_x, start_y  out  10 each  latched position.
- char0..char9  out  8 each  latched characters.
- str_length  out  4  number of characters currently revealed.

Behaviour:
- Reset: state IDLE; grant=0, busy=0, done=0, start_x=start_y=0, char0..char9=8'd32, str_length=0, counters=0. Reset mid-operation aborts immediately with no done pulse.
- IDLE:
  - Any req bit high at cycle n: select winner (fixed priority, lowest index wins).
  - grant[winner]=1 and state=LOAD at n+1.
- LOAD (1 cycle):
  - Latch the winner's chars, position and length.
  - Length clamped: len_in>10 -> 10.
  - chars at index >= latched length forced to 8'd32.
  - str_length=0, frame counter=0.
  - frame_tick during LOAD is ignored.
  - Next state: REVEAL, or HOLD if latched length==0.
- REVEAL:
  - Each frame_tick increments the frame counter.
  - When the counter reaches REVEAL_FRAMES: str_length++ and counter=0, both in the same cycle.
  - When str_length reaches the latched length: go to HOLD with counter=0.
- HOLD:
  - Count frame_ticks.
  - On the HOLD_FRAMES-th tick go to DONE.
- DONE (1 cycle):
  - done=1, grant=0, str_length=0, chars reset to 8'd32; next state IDLE.
  - A req still high in IDLE is re-arbitrated normally, so the earliest re-grant is 2 cycles after DONE.
- Abandon: if req[owner] drops in LOAD, REVEAL or HOLD, the next cycle is IDLE with grant=0, str_length=0 and no done pulse.
- Simultaneous events:
  - Abandon takes precedence over a frame_tick in the same cycle.
  - New requests arriving while busy are not sampled until IDLE.
- Inputs from non-owners are ignored while busy. Latched values are stable for the whole grant, even if str_in changes.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: TEXT_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at (last_owner+1) mod NUM_REQ; last_owner resets to NUM_REQ-1, so the first grant favours index 0. last_owner updates on every grant, including abandoned ones.
- Undefined: fixed priority, lowest index wins; no last_owner register.

Test Plan:
- Reset: assert rst 3 cycles during REVEAL -> outputs return to reset values next cycle, chars=8'd32, no done pulse.
- Basic reveal: REVEAL_FRAMES=2, HOLD_FRAMES=3, req[1]=1, len=5, string "SCORE", pos x=100 y=40:
  - grant=4'b0010 at n+1.
  - Chars latched at n+2.
  - str_length steps 1..5 on frame ticks 2,4,6,8,10.
  - done pulses one cycle after the 13th tick.
  - char5..char9=32.
- Clamp and zero length:
  - len_in=15 -> str_length saturates at 10.
  - len_in=0 -> REVEAL skipped, str_length stays 0, done after HOLD_FRAMES ticks.
- Priority: req=4'b1010 in the same cycle -> grant=4'b0010. After done with both still high:
  - default build: index 1 again.
  - TEXT_ARB_RR_EN build: index 3.
- Abandon: drop req[owner] on the same cycle as a frame_tick in REVEAL -> IDLE next cycle, str_length=0, no increment, done never pulses.
- Non-owner isolation: change str_in for the owner and for others mid-HOLD -> char outputs unchanged until DONE.
